// File: rtl/mem_stage.sv
// MEM pipeline stage: word-addressed data RAM with a post-reset clear sequencer
// and the MEM/WB pipeline register. Optional trap: define MEM_MISALIGN_TRAP_EN.
module mem_stage #(
    parameter int ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite_in,
    input  logic        MemtoRead_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [31:0] ALUResult_in,
    input  logic [31:0] WriteData_in,
    input  logic [4:0]  WriteReg_in,
    output logic        RegWrite_out,
    output logic        MemtoRead_out,
    output logic [31:0] ReadData_out,
    output logic [31:0] ALUResult_out,
    output logic [4:0]  WriteReg_out,
    output logic        busy,
    output logic        misalign
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [ADDR_BITS-1:0] clr_cnt_q, clr_cnt_d;
    logic [31:0]          mem_q [DEPTH];

    logic [ADDR_BITS-1:0] addr_s;
    logic                 trap_s;
    logic                 mem_we_s;
    logic [ADDR_BITS-1:0] mem_waddr_s;
    logic [31:0]          mem_wdata_s;

    logic        reg_write_d, memto_read_d, misalign_d;
    logic [31:0] read_data_d, alu_result_d;
    logic [4:0]  write_reg_d;
    logic        reg_write_q, memto_read_q, misalign_q;
    logic [31:0] read_data_q, alu_result_q;
    logic [4:0]  write_reg_q;

    // Upper address bits are dropped on purpose, so accesses alias modulo the RAM size.
    assign addr_s = ALUResult_in[ADDR_BITS+1:2];

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap_s = (state_q == ST_RUN) && (MemRead_in || MemWrite_in) &&
                    (ALUResult_in[1:0] != 2'b00);
`else
    assign trap_s = 1'b0;
`endif

    // Clear-sequencer next state: one word per cycle, RUN after the last word.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + {{(ADDR_BITS-1){1'b0}}, 1'b1};
                if (clr_cnt_q == {ADDR_BITS{1'b1}}) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = {ADDR_BITS{1'b0}};
            end
        endcase
    end

    // Single RAM write port shared by the clear sequencer and stores.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = addr_s;
        mem_wdata_s = WriteData_in;
        if (state_q == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = clr_cnt_q;
            mem_wdata_s = 32'h0000_0000;
        end else begin
            mem_we_s    = MemWrite_in && !trap_s;
        end
    end

    // MEM/WB next values; write-first when load and store coincide.
    always_comb begin
        reg_write_d  = 1'b0;
        memto_read_d = 1'b0;
        read_data_d  = 32'h0000_0000;
        alu_result_d = 32'h0000_0000;
        write_reg_d  = 5'd0;
        misalign_d   = 1'b0;
        if (state_q == ST_RUN) begin
            reg_write_d  = RegWrite_in && !trap_s;
            memto_read_d = MemtoRead_in;
            alu_result_d = ALUResult_in;
            write_reg_d  = WriteReg_in;
            misalign_d   = trap_s;
            if (MemRead_in && !trap_s) begin
                if (MemWrite_in) begin
                    read_data_d = WriteData_in;
                end else begin
                    read_data_d = mem_q[addr_s];
                end
            end else begin
                read_data_d = 32'h0000_0000;
            end
        end else begin
            misalign_d = 1'b0;
        end
    end

    // RAM array: no reset, contents are zeroed by the clear sequencer instead.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Sequencer state and MEM/WB register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_CLEAR;
            clr_cnt_q    <= {ADDR_BITS{1'b0}};
            reg_write_q  <= 1'b0;
            memto_read_q <= 1'b0;
            read_data_q  <= 32'h0000_0000;
            alu_result_q <= 32'h0000_0000;
            write_reg_q  <= 5'd0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            reg_write_q  <= reg_write_d;
            memto_read_q <= memto_read_d;
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            write_reg_q  <= write_reg_d;
            misalign_q   <= misalign_d;
        end
    end

    assign RegWrite_out  = reg_write_q;
    assign MemtoRead_out = memto_read_q;
    assign ReadData_out  = read_data_q;
    assign ALUResult_out = alu_result_q;
    assign WriteReg_out  = write_reg_q;
    assign misalign      = misalign_q;
    assign busy          = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: clear sequencing, load/store, write-first,
// aliasing, mid-operation reset and the optional misalignment trap.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        RegWrite_in, MemtoRead_in, MemRead_in, MemWrite_in;
    logic [31:0] ALUResult_in, WriteData_in;
    logic [4:0]  WriteReg_in;
    logic        RegWrite_out, MemtoRead_out, busy, misalign;
    logic [31:0] ReadData_out, ALUResult_out;
    logic [4:0]  WriteReg_out;

    int total;
    int bad;
    int n;

    mem_stage dut (
        .clk(clk), .reset(reset),
        .RegWrite_in(RegWrite_in), .MemtoRead_in(MemtoRead_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .ALUResult_in(ALUResult_in), .WriteData_in(WriteData_in),
        .WriteReg_in(WriteReg_in),
        .RegWrite_out(RegWrite_out), .MemtoRead_out(MemtoRead_out),
        .ReadData_out(ReadData_out), .ALUResult_out(ALUResult_out),
        .WriteReg_out(WriteReg_out), .busy(busy), .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one access after a falling edge; outputs are valid at the next falling edge.
    task automatic access(input logic rw, input logic m2r, input logic mr, input logic mw,
                          input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
        RegWrite_in  = rw;
        MemtoRead_in = m2r;
        MemRead_in   = mr;
        MemWrite_in  = mw;
        ALUResult_in = alu;
        WriteData_in = wd;
        WriteReg_in  = wr;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        RegWrite_in = 1'b0; MemtoRead_in = 1'b0; MemRead_in = 1'b0; MemWrite_in = 1'b0;
        ALUResult_in = 32'h0; WriteData_in = 32'h0; WriteReg_in = 5'd0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rw"},   {31'd0, RegWrite_out}, 32'd0);
        check({tag, "_m2r"},  {31'd0, MemtoRead_out}, 32'd0);
        check({tag, "_rd"},   ReadData_out, 32'h0);
        check({tag, "_alu"},  ALUResult_out, 32'h0);
        check({tag, "_wr"},   {27'd0, WriteReg_out}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_mis"},  {31'd0, misalign}, 32'd0);
    endtask

    // Count rising edges until busy drops, bounded so a stuck sequencer still ends the run.
    task automatic count_busy(input string tag);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(tag, n, 32'd256);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle_inputs();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");

        // Drive garbage during CLEAR: it must be ignored.
        reset = 1'b1;
        RegWrite_in = 1'b1; MemWrite_in = 1'b1; MemRead_in = 1'b1; MemtoRead_in = 1'b1;
        ALUResult_in = 32'h0000_0040; WriteData_in = 32'hCAFE_F00D; WriteReg_in = 5'd9;
        @(negedge clk);
        n = 1;
        check("clear_rd", ReadData_out, 32'h0);
        check("clear_rw", {31'd0, RegWrite_out}, 32'd0);
        while (busy === 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("busy_len", n, 32'd256);
        check("clear_alu", ALUResult_out, 32'h0);

        // First RUN cycle: load the last word.
        access(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_03FC, 32'h0, 5'd3);
        check("ld3fc_rd", ReadData_out, 32'h0);
        check("ld3fc_alu", ALUResult_out, 32'h0000_03FC);
        check("ld_garbage", 32'h0, 32'h0 | ReadData_out);

        access(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 5'd3);
        check("ld40_clear", ReadData_out, 32'h0);

        // Store then load the same word.
        access(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0);
        check("st10_rd", ReadData_out, 32'h0);
        check("st10_rw", {31'd0, RegWrite_out}, 32'd0);
        access(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 5'd7);
        check("ld10_rd", ReadData_out, 32'hDEAD_BEEF);
        check("ld10_m2r", {31'd0, MemtoRead_out}, 32'd1);
        check("ld10_wr", {27'd0, WriteReg_out}, 32'd7);
        check("ld10_rw", {31'd0, RegWrite_out}, 32'd1);
        check("ld10_alu", ALUResult_out, 32'h0000_0010);

        // ALU pass-through with no memory access.
        access(1'b1, 1'b0, 1'b0, 1'b0, 32'h8765_4321, 32'hFFFF_FFFF, 5'd31);
        check("alu_pass", ALUResult_out, 32'h8765_4321);
        check("alu_rd", ReadData_out, 32'h0);
        check("alu_wr", {27'd0, WriteReg_out}, 32'd31);
        check("alu_m2r", {31'd0, MemtoRead_out}, 32'd0);

        // Write-first.
        access(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 5'd4);
        check("wf_rd", ReadData_out, 32'h1234_5678);
        access(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        access(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 5'd4);
        check("wf_later", ReadData_out, 32'h1234_5678);

        // Aliasing: 0x404 and 0x004 hit the same word.
        access(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0404, 32'hA5A5_A5A5, 5'd0);
        access(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 5'd5);
        check("wrap_rd", ReadData_out, 32'hA5A5_A5A5);
        access(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 5'd5);
        check("ld10_again", ReadData_out, 32'hDEAD_BEEF);

        // Misaligned store.
        access(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0031, 32'hFFFF_FFFF, 5'd6);
`ifdef MEM_MISALIGN_TRAP_EN
        check("mis_flag", {31'd0, misalign}, 32'd1);
        check("mis_rw", {31'd0, RegWrite_out}, 32'd0);
`else
        check("mis_flag", {31'd0, misalign}, 32'd0);
        check("mis_rw", {31'd0, RegWrite_out}, 32'd1);
`endif
        check("mis_alu", ALUResult_out, 32'h0000_0031);
        check("mis_wr", {27'd0, WriteReg_out}, 32'd6);
        access(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0030, 32'h0, 5'd6);
        check("mis_oneshot", {31'd0, misalign}, 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
        check("mis_ld30", ReadData_out, 32'h0);
`else
        check("mis_ld30", ReadData_out, 32'hFFFF_FFFF);
`endif

        // Asynchronous reset in RUN clears outputs immediately.
        RegWrite_in = 1'b1; MemtoRead_in = 1'b1; MemRead_in = 1'b1; MemWrite_in = 1'b0;
        ALUResult_in = 32'h0000_0020; WriteReg_in = 5'd8;
        @(posedge clk);
        #2;
        check("pre_rst_rd", ReadData_out, 32'h1234_5678);
        reset = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        @(negedge clk);
        reset = 1'b1;
        repeat (100) @(negedge clk);
        check("mid_clear_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        count_busy("busy_len2");

        access(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 5'd1);
        check("reclr_10", ReadData_out, 32'h0);
        access(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 5'd1);
        check("reclr_20", ReadData_out, 32'h0);
        access(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 5'd1);
        check("reclr_04", ReadData_out, 32'h0);
        access(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0030, 32'h0, 5'd1);
        check("reclr_30", ReadData_out, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, directly downstream of the EX/MEM pipeline register. Takes the registered EX/MEM control and data, performs the data-memory load or store against an on-chip word-addressed RAM, and registers the results as the MEM/WB pipeline register for write-back. After every reset, a built-in clear sequencer zeroes the RAM and holds `busy` high, so upstream logic must stall until it completes.

## Interface
- `ADDR_BITS`, 8: word-address width; RAM depth = 2^ADDR_BITS 32-bit words.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `RegWrite_in` input 1: register write-back enable from EX/MEM.
- `MemtoRead_in` input 1: write-back source select from EX/MEM (1 = memory data, 0 = ALU result).
- `MemRead_in` input 1: load enable.
- `MemWrite_in` input 1: store enable.
- `ALUResult_in` input 32: byte address for loads/stores; also the ALU result for write-back.
- `WriteData_in` input 32: store data.
- `WriteReg_in` input 5: destination register.
- `RegWrite_out` output 1: MEM/WB write-back enable.
- `MemtoRead_out` output 1: MEM/WB write-back source select.
- `ReadData_out` output 32: MEM/WB load data.
- `ALUResult_out` output 32: MEM/WB ALU result.
- `WriteReg_out` output 5: MEM/WB destination register.
- `busy` output 1: high while the clear sequencer runs; upstream stalls.
- `misalign` output 1: one-cycle misaligned-access flag; tied 0 unless the configuration macro is defined.

## Operation
- The block has two FSM states, CLEAR and RUN.
- `reset` low forces CLEAR and resets the clear counter to 0.
- In CLEAR:
  - One word is written per cycle: mem[counter] <= 0, then counter increments.
  - After word 2^ADDR_BITS-1 is written, the FSM moves to RUN.
  - `busy` = 1 throughout CLEAR.
  - All inputs are ignored: no stores, no loads.
  - All pipeline outputs are registered to 0.
- In RUN:
  - `busy` = 0.
  - Word address = `ALUResult_in[ADDR_BITS+1:2]`. Higher address bits are ignored, so addresses alias (wrap) modulo the RAM size.
  - `MemWrite_in`=1: mem[addr] <= `WriteData_in` at the clock edge.
  - `MemRead_in`=1: `ReadData_out` <= mem[addr].
  - `MemRead_in`=1 and `MemWrite_in`=1 together: write-first. The store commits and `ReadData_out` <= `WriteData_in`.
  - `MemRead_in`=0: `ReadData_out` <= 0.
  - `RegWrite_out`, `MemtoRead_out`, `ALUResult_out` and `WriteReg_out` register their inputs unchanged.
- A store followed by a load to the same address on the next cycle returns the stored data; RAM writes are visible one edge later.

## Timing
- Reset values: all outputs are 0 while `reset` is low. The exception is `busy`, which is 1 during reset and goes low only after CLEAR completes.
- CLEAR takes exactly 2^ADDR_BITS cycles after `reset` deasserts (256 for the default). `busy` falls on the edge that writes the last word.
- RUN latency is one cycle: inputs sampled at edge N appear on the outputs after edge N.
- Reset asserted mid-operation (in RUN, or partway through CLEAR):
  - Outputs clear immediately (asynchronous reset).
  - The FSM returns to CLEAR and the whole RAM is re-zeroed from word 0.
- No backpressure exists in RUN; a new access is accepted every cycle.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - Trigger: in RUN, `MemRead_in` or `MemWrite_in` is 1 and `ALUResult_in[1:0]` != 0.
  - The store is suppressed.
  - `ReadData_out` <= 0 and `RegWrite_out` <= 0.
  - `misalign` <= 1 for that one registered cycle.
  - All other outputs pass through as normal.
- `MEM_MISALIGN_TRAP_EN` undefined:
  - `ALUResult_in[1:0]` is ignored and misaligned accesses behave as aligned ones.
  - `misalign` is constant 0.

## Test plan
- Release `reset`, then sample `busy` -> `busy`=1 for exactly 256 cycles, then 0. A load from address 0x3FC in the first RUN cycle returns 0x00000000.
- Store 0xDEADBEEF to address 0x10, then load 0x10 on the next cycle -> `ReadData_out`=0xDEADBEEF one cycle after the load. Expect `MemtoRead_out`=1 and `WriteReg_out` equal to the load's `WriteReg_in`.
- Simultaneous `MemRead_in`=1, `MemWrite_in`=1, address 0x20, data 0x12345678 -> `ReadData_out`=0x12345678. A later load from 0x20 also returns 0x12345678.
- Store 0xA5A5A5A5 to address 0x404 (ADDR_BITS=8), then load 0x004 -> returns 0xA5A5A5A5 (wrap-around).
- Assert `reset` low at cycle 100 of CLEAR, after earlier stores in RUN, then release -> `busy` is high for a full 256 cycles and all previously stored words read 0.
- With `MEM_MISALIGN_TRAP_EN` defined: store 0xFFFFFFFF to address 0x31, with `RegWrite_in`=1 -> `misalign`=1 for one cycle, `RegWrite_out`=0, and a load from 0x30 still returns the old value.
